// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// - state_e : FSM state encoding. 2'd3 is unused and recovers to StIdle.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/full_sub_bit.sv
// Single-bit full subtractor: d = a - b - bi, with borrow out bo.
// Ports:
//   a, b  minuend / subtrahend bit
//   bi    borrow in
//   d     difference bit
//   bo    borrow out
module full_sub_bit (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    logic d1, b1, b2;

    // First half-subtract stage: a - b.
    assign d1 = a ^ b;
    assign b1 = ~a & b;

    // Second half-subtract stage: (a - b) - bi.
    assign d  = d1 ^ bi;
    assign b2 = ~d1 & bi;

    assign bo = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b, one bit per clock, LSB first.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load request, accepted in IDLE or DONE
//   a, b        operands, captured on accept
//   busy        high while shifting
//   done        one-cycle pulse when diff/bout are valid
//   diff        a - b modulo 2^WIDTH, held until the next accept
//   bout        final borrow (a < b unsigned)
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e          state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] diff_q;
    logic             br_q;
    logic             bout_q;
    logic [CntW-1:0]  cnt_q;

    logic slice_d;
    logic slice_bo;

    full_sub_bit u_slice (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .bi (br_q),
        .d  (slice_d),
        .bo (slice_bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                // DONE accepts a new operation exactly like IDLE (back-to-back).
                StIdle, StDone: begin
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StShift;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StShift: begin
                    diff_q <= {slice_d, diff_q[WIDTH-1:1]};
                    a_sr_q <= a_sr_q >> 1;
                    b_sr_q <= b_sr_q >> 1;
                    br_q   <= slice_bo;
                    cnt_q  <= cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        bout_q  <= slice_bo;
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, bout;
    logic [W-1:0] diff;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        int unsigned  at_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc       = 0;
    int unsigned next_free = 0;
    int          errors    = 0;
    int          checks    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("diff", 32'(diff), 32'(e.d));
                check("bout", 32'(bout), 32'(e.bo));
                check("latency", cyc, e.at_cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    // Reference: accept at edge N, done visible after edge N+8, next accept at N+9.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
        exp_t        e;
        int unsigned acc;
        while (cyc + 1 < next_free) @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        acc   = cyc + 1;
        e.d      = W'((int'(x) - int'(y)) & ((1 << W) - 1));
        e.bo     = (x < y);
        e.at_cyc = acc + W;
        exp_q.push_back(e);
        next_free = acc + W + 1;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    logic [W-1:0] corners[6];

    initial begin
        corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_diff", 32'(diff), 0);
        check("rst_bout", 32'(bout), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with idle gaps.
        issue(8'h05, 8'h03, 0); drain();
        issue(8'h03, 8'h05, 0); drain();
        issue(8'h00, 8'hFF, 0); drain();
        issue(8'hFF, 8'hFF, 0); drain();
        issue(8'hA5, 8'h00, 0); drain();

        // start re-asserted with other operands mid-operation must be ignored.
        issue(8'h5A, 8'h3C, 0);
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'h01;
        repeat (3) @(negedge clk);
        start = 1'b0;
        drain();

        // Reset in SHIFT cycle 4 abandons the operation.
        issue(8'h55, 8'h22, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_diff", 32'(diff), 0);
        check("midrst_bout", 32'(bout), 0);
        exp_q.delete();
        next_free = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        issue(8'h10, 8'h20, 0); drain();

        // Back-to-back with start held high: corners, then random operands.
        foreach (corners[i]) foreach (corners[j]) issue(corners[i], corners[j], 1);
        for (int k = 0; k < 1500; k++) issue(W'($urandom), W'($urandom), 1);
        start = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
